// File: rtl/mii_tx_arbiter.sv
// Two-requester frame scheduler and XGMII-style encoder for the 64-bit MII TX bus.
// Define MII_ARB_PRIO_EN to give requester 1 strict priority instead of round-robin.
module mii_tx_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8,
    parameter int IFG_WORDS  = 2
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_data0,
    input  logic [CTRL_WIDTH-1:0] i_keep0,
    input  logic                  i_last0,
    input  logic                  i_valid0,
    output logic                  o_ready0,
    input  logic [DATA_WIDTH-1:0] i_data1,
    input  logic [CTRL_WIDTH-1:0] i_keep1,
    input  logic                  i_last1,
    input  logic                  i_valid1,
    output logic                  o_ready1,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic [CTRL_WIDTH-1:0] o_tx_ctrl,
    output logic                  o_grant,
    output logic                  o_busy,
    output logic                  o_err
);
    localparam logic [7:0] CH_IDLE = 8'h07;
    localparam logic [7:0] CH_TERM = 8'hFD;
    localparam logic [7:0] CH_ERR  = 8'hFE;

    localparam logic [DATA_WIDTH-1:0] IDLE_WORD  = {CTRL_WIDTH{CH_IDLE}};
    localparam logic [DATA_WIDTH-1:0] ERR_WORD   = {CTRL_WIDTH{CH_ERR}};
    localparam logic [DATA_WIDTH-1:0] TERM_WORD  = {{(CTRL_WIDTH-1){CH_IDLE}}, CH_TERM};
    localparam logic [DATA_WIDTH-1:0] START_WORD = 64'hD5555555555555FB;
    localparam logic [CTRL_WIDTH-1:0] START_CTRL = 8'h01;
    localparam logic [3:0]            IFG_LOAD   = 4'(IFG_WORDS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_TERM, ST_IFG} state_t;

    state_t                  state_reg;
    logic                    grant_reg;
    logic                    last_grant_reg;
    logic [3:0]              ifg_cnt_reg;
    logic [DATA_WIDTH-1:0]   tx_data_reg;
    logic [CTRL_WIDTH-1:0]   tx_ctrl_reg;
    logic                    busy_reg;
    logic                    err_reg;

    logic [DATA_WIDTH-1:0]   sel_data;
    logic [CTRL_WIDTH-1:0]   sel_keep;
    logic                    sel_last;
    logic                    sel_valid;
    logic                    pick;
    logic                    keep_contig;
    logic                    keep_full;
    logic [3:0]              keep_len;
    logic [DATA_WIDTH-1:0]   part_data;
    logic [CTRL_WIDTH-1:0]   part_ctrl;

    assign sel_data  = grant_reg ? i_data1  : i_data0;
    assign sel_keep  = grant_reg ? i_keep1  : i_keep0;
    assign sel_last  = grant_reg ? i_last1  : i_last0;
    assign sel_valid = grant_reg ? i_valid1 : i_valid0;

    // A keep mask is usable as-is only when it is a non-empty run of ones from lane 0.
    assign keep_contig = (sel_keep != '0) && ((sel_keep & (sel_keep + 8'd1)) == '0);
    assign keep_full   = (sel_keep == '1);
    assign keep_len    = 4'($countones(sel_keep));

    generate
        for (genvar gi = 0; gi < CTRL_WIDTH; gi++) begin : g_lane
            localparam logic [3:0] LANE = 4'(gi);
            assign part_data[gi*8 +: 8] = (LANE < keep_len)  ? sel_data[gi*8 +: 8] :
                                          (LANE == keep_len) ? CH_TERM : CH_IDLE;
            assign part_ctrl[gi]        = (LANE >= keep_len);
        end
    endgenerate

    always_comb begin
`ifdef MII_ARB_PRIO_EN
        pick = i_valid1;
`else
        pick = (i_valid0 && i_valid1) ? ~last_grant_reg : i_valid1;
`endif
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            ifg_cnt_reg    <= '0;
            tx_data_reg    <= IDLE_WORD;
            tx_ctrl_reg    <= '1;
            busy_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    tx_data_reg <= IDLE_WORD;
                    tx_ctrl_reg <= '1;
                    busy_reg    <= 1'b0;
                    if (i_valid0 || i_valid1) begin
                        grant_reg      <= pick;
                        last_grant_reg <= pick;
                        tx_data_reg    <= START_WORD;
                        tx_ctrl_reg    <= START_CTRL;
                        busy_reg       <= 1'b1;
                        state_reg      <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    busy_reg <= 1'b1;
                    if (!sel_valid) begin
                        // Underrun: the frame is corrupted on the wire but kept open.
                        tx_data_reg <= ERR_WORD;
                        tx_ctrl_reg <= '1;
                        err_reg     <= 1'b1;
                    end else if (!sel_last) begin
                        tx_data_reg <= sel_data;
                        tx_ctrl_reg <= '0;
                    end else if (keep_contig && !keep_full) begin
                        tx_data_reg <= part_data;
                        tx_ctrl_reg <= part_ctrl;
                        ifg_cnt_reg <= IFG_LOAD;
                        state_reg   <= ST_IFG;
                    end else begin
                        tx_data_reg <= sel_data;
                        tx_ctrl_reg <= '0;
                        err_reg     <= !keep_contig;
                        state_reg   <= ST_TERM;
                    end
                end
                ST_TERM: begin
                    tx_data_reg <= TERM_WORD;
                    tx_ctrl_reg <= '1;
                    busy_reg    <= 1'b1;
                    ifg_cnt_reg <= IFG_LOAD;
                    state_reg   <= ST_IFG;
                end
                ST_IFG: begin
                    tx_data_reg <= IDLE_WORD;
                    tx_ctrl_reg <= '1;
                    busy_reg    <= 1'b0;
                    if (ifg_cnt_reg == '0) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        ifg_cnt_reg <= ifg_cnt_reg - 4'd1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign o_ready0  = (state_reg == ST_DATA) && !grant_reg;
    assign o_ready1  = (state_reg == ST_DATA) &&  grant_reg;
    assign o_tx_data = tx_data_reg;
    assign o_tx_ctrl = tx_ctrl_reg;
    assign o_grant   = grant_reg;
    assign o_busy    = busy_reg;
    assign o_err     = err_reg;

endmodule

// File: doc/mii_tx_arbiter.md
# mii_tx_arbiter

Two-requester transmit scheduler for the 1.6T MII TX path (64-bit data, 8-bit control, XGMII-style lane encoding, lane 0 = bits [7:0]). It arbitrates whole frames from two word-stream sources and encodes them onto the single MII TX bus. Encoding covers start/preamble, data, terminate, error and idle characters, and it enforces a minimum inter-frame gap. It sits between the frame generators and the MII TX bus, and its output feeds the existing MII checker.

## Interface
- DATA_WIDTH, 64, MII data width; only 64 is supported.
- CTRL_WIDTH, 8, one control bit per byte lane; only 8 is supported.
- IFG_WORDS, 2, idle words inserted between frames; legal range 1..15.

- clk  in  1  system clock; all logic on its rising edge.
- i_rst_n  in  1  reset, asynchronous and active-low.
- i_data0 / i_data1  in  64  requester word; byte n in bits [8n+7:8n].
- i_keep0 / i_keep1  in  8  valid-byte mask, sampled only on the last word.
- i_last0 / i_last1  in  1  marks the final word of the frame.
- i_valid0 / i_valid1  in  1  word valid.
- o_ready0 / o_ready1  out  1  word accepted when valid & ready.
- o_tx_data  out  64  MII TX data, registered.
- o_tx_ctrl  out  8  MII TX control, registered; bit n=1 means lane n is a control character.
- o_grant  out  1  index of the requester owning the current or most recent frame.
- o_busy  out  1  high from the start word through the terminate word.
- o_err  out  1  one-cycle pulse on a protocol error.

## Operation
- Characters: idle 0x07, start 0xFB, terminate 0xFD, error 0xFE, preamble 0x55, SFD 0xD5.
- States: IDLE, DATA, TERM, IFG.
- IDLE:
  - Output all-idle: data 0x0707070707070707, ctrl 0xFF.
  - If any valid is high: choose a grant and register the start word (data 0xD5555555555555FB, ctrl 0x01); go to DATA.
- DATA:
  - o_ready[grant] = 1; the other ready is 0. Each accepted word appears on o_tx next cycle with ctrl 0x00.
  - Valid low mid-frame: emit the error word (0xFEFEFEFEFEFEFEFE, ctrl 0xFF) for each such cycle, pulse o_err, and stay in DATA.
- Last word, keep = 2^n−1 with n in 1..7: lanes 0..n−1 carry data, lane n carries 0xFD, lanes >n carry 0x07; ctrl bits n..7 = 1. Go to IFG.
- Last word, keep = 0xFF: emit the full data word with ctrl 0x00 and go to TERM. TERM emits 0x07070707070707FD with ctrl 0xFF, then goes to IFG.
- Non-contiguous or zero keep on the last word: treat as 0xFF and pulse o_err.
- IFG: emit idle words until exactly IFG_WORDS idle words have followed the terminate-bearing word, then go to IDLE.
- Arbitration: round-robin at frame boundaries only.
  - If both requesters are valid, the grant goes to the requester not granted last.
  - After reset, "last granted" = 1, so requester 0 wins the first tie.
  - A grant never changes mid-frame.

## Timing
- Reset values (asynchronous): o_tx_data 0x0707070707070707, o_tx_ctrl 0xFF, o_ready* 0, o_grant 0, o_busy 0, o_err 0, state IDLE.
- Reset mid-frame: the bus returns to idle immediately; no terminate is emitted; the in-flight frame is dropped.
- First valid seen in IDLE at cycle N:
  - Start word on o_tx at N+1.
  - o_ready high from N+1.
  - First data word on o_tx at N+2.
- Data latency is 1 cycle from acceptance to o_tx; throughput is 1 word per cycle.
- Back-to-back requests: exactly IFG_WORDS idle words lie between the terminate-bearing word and the next start word.
- o_err asserts in the same cycle as the offending output word.
- Simultaneous valid on both requesters in IDLE: only one start; the loser holds valid with ready low until its turn.

## Configuration
- MII_ARB_PRIO_EN:
  - Defined: requester 1 has strict priority at every frame boundary.
  - Undefined: round-robin as described above.
- Nothing else changes under the macro.

## Test plan
- Single 3-word frame on req0, last keep 0x0F → start word 0xD5555555555555FB/0x01, two data words ctrl 0x00, then last word with lane 4 = 0xFD, lanes 5–7 = 0x07, ctrl 0xF0; then 2 idle words.
- Frame whose last word has keep 0xFF → data word ctrl 0x00 followed by TERM word 0x07070707070707FD/0xFF.
- Both requesters continuously valid with 2-word frames → grants alternate 0,1,0,1; exactly IFG_WORDS idle words between frames. With MII_ARB_PRIO_EN defined, req1 always wins.
- i_valid0 dropped for 2 cycles mid-frame → two 0xFE…FE/0xFF words, o_err high for 2 cycles, frame resumes intact.
- Last-word keep 0x05 → treated as 0xFF: TERM word emitted, o_err pulses once.
- i_rst_n asserted during DATA → outputs immediately 0x0707070707070707/0xFF with ready 0; after release, req0 wins the first tie.
